flag_ctx_unit: RTL and testbench

//   Parametrised condition-flag unit: holds the committed Z/V/N/C flags and

---
 rtl/flag_ctx_unit.sv | 117 +++++++++++
 tb/tb_flag_ctx_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/flag_ctx_unit.sv
// rtl/flag_ctx_unit.sv - condition flag unit with ALU bypass and LIFO flag save/restore stack
module flag_ctx_unit #(
    parameter int STACK_DEPTH = 4,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flag_we,
    input  logic                             alu_z,
    input  logic                             alu_v,
    input  logic                             alu_n,
    input  logic                             alu_c,
    input  logic                             flag_push,
    input  logic                             flag_pop,
    input  logic                             cond_valid,
    input  logic [2:0]                       cond,
    output logic                             take,
    output logic [3:0]                       flags,
    output logic [$clog2(STACK_DEPTH):0]     stack_depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    logic [3:0]    r_flags;
    logic [DW-1:0] r_depth;
    logic          r_err;
    logic [3:0]    r_stack [STACK_DEPTH];

    logic [3:0]    w_alu;
    logic [3:0]    w_eff;
    logic          w_s;
    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_wr_idx;
    logic [PW-1:0] w_top_idx;
    logic          w_f;

    assign w_alu   = {alu_c, alu_n, alu_v, alu_z};
    assign w_eff   = (BYPASS && flag_we) ? w_alu : r_flags;
    assign w_s     = w_eff[2] ^ w_eff[1];
    assign w_full  = (r_depth == DW'(STACK_DEPTH));
    assign w_empty = (r_depth == '0);

    // Depth is a power of two, so the low bits wrap cleanly: depth=STACK_DEPTH gives top index STACK_DEPTH-1.
    assign w_wr_idx  = r_depth[PW-1:0];
    assign w_top_idx = r_depth[PW-1:0] - PW'(1);

    always_comb begin
        w_f = 1'b0;
        case (cond)
            3'b000: w_f = ~w_eff[0];
            3'b001: w_f = w_eff[0];
            3'b010: w_f = ~w_eff[0] & ~w_s;
            3'b011: w_f = w_s;
            3'b100: w_f = ~w_s;
            3'b101: w_f = w_eff[0] | w_s;
            3'b110: w_f = w_eff[1];
            default: w_f = 1'b1;
        endcase
    end

    assign take        = cond_valid & w_f;
    assign flags       = r_flags;
    assign stack_depth = r_depth;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign stack_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            case ({flag_push, flag_pop})
                2'b10: begin
                    if (!w_full) r_depth <= r_depth + DW'(1);
                    else         r_err   <= 1'b1;
                    if (flag_we) r_flags <= w_alu;
                end
                2'b01: begin
                    if (!w_empty) begin
                        r_flags <= r_stack[w_top_idx];
                        r_depth <= r_depth - DW'(1);
                    end else begin
                        r_err <= 1'b1;
                        if (flag_we) r_flags <= w_alu;
                    end
                end
                2'b11: begin
                    if (!w_empty) begin
                        r_flags <= r_stack[w_top_idx];
                    end else begin
                        r_err <= 1'b1;
                        if (flag_we) r_flags <= w_alu;
                    end
                end
                default: begin
                    if (flag_we) r_flags <= w_alu;
                end
            endcase
        end
    end

    // Stack contents need no reset; validity is tracked by r_depth alone.
    always_ff @(posedge clk) begin
        if (flag_push && !flag_pop && !w_full)
            r_stack[w_wr_idx] <= r_flags;
        else if (flag_push && flag_pop && !w_empty)
            r_stack[w_top_idx] <= r_flags;
    end

endmodule

// File: tb/tb_flag_ctx_unit.sv
// tb/tb_flag_ctx_unit.sv - directed self-checking bench for flag_ctx_unit
module tb_flag_ctx_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_we, alu_z, alu_v, alu_n, alu_c;
    logic       flag_push, flag_pop, cond_valid;
    logic [2:0] cond;

    logic       take, take_nb;
    logic [3:0] flags, flags_nb;
    logic [2:0] depth, depth_nb;
    logic       full, full_nb, empty, empty_nb, err, err_nb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    flag_ctx_unit #(.STACK_DEPTH(4), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n), .alu_c(alu_c),
        .flag_push(flag_push), .flag_pop(flag_pop),
        .cond_valid(cond_valid), .cond(cond),
        .take(take), .flags(flags), .stack_depth(depth),
        .stack_full(full), .stack_empty(empty), .stack_err(err)
    );

    flag_ctx_unit #(.STACK_DEPTH(4), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n), .alu_c(alu_c),
        .flag_push(flag_push), .flag_pop(flag_pop),
        .cond_valid(cond_valid), .cond(cond),
        .take(take_nb), .flags(flags_nb), .stack_depth(depth_nb),
        .stack_full(full_nb), .stack_empty(empty_nb), .stack_err(err_nb)
    );

    function automatic logic exp_take(input logic [2:0] c, input logic [3:0] f);
        logic z, v, n, lt;
        z = f[0]; v = f[1]; n = f[2];
        lt = (n && !v) || (!n && v);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !lt;
            3'd3: return lt;
            3'd4: return !lt;
            3'd5: return z || lt;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] f);
        {alu_c, alu_n, alu_v, alu_z} = f;
    endtask

    task automatic idle();
        flag_we = 0; flag_push = 0; flag_pop = 0; cond_valid = 0; cond = 3'd0;
        set_alu(4'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        idle();
        rst_n = 0;
        #2;
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #3;
        total++; if (flags !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", flags); end
        total++; if (depth !== 3'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth); end
        total++; if ({full, empty, err} !== 3'b010) begin bad++; $display("FAIL reset_status full/empty/err got=%b want=010", {full, empty, err}); end
        total++; if (take !== 1'b0) begin bad++; $display("FAIL reset_take got=%b want=0", take); end
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_flag_update();
        do_reset();
        flag_we = 1; set_alu(4'b0001);
        tick();
        flag_we = 0; set_alu(4'b0000);
        total++; if (flags !== 4'b0001) begin bad++; $display("FAIL upd_flags got=%b want=0001", flags); end
        cond_valid = 1; cond = 3'b001;
        #1;
        total++; if (take !== 1'b1) begin bad++; $display("FAIL upd_take_eq got=%b want=1", take); end
        cond_valid = 0;
    endtask

    task automatic test_bypass();
        do_reset();
        cond_valid = 1; cond = 3'b001; flag_we = 1; set_alu(4'b0001);
        #1;
        total++; if (take !== 1'b1) begin bad++; $display("FAIL bypass_on got=%b want=1", take); end
        total++; if (take_nb !== 1'b0) begin bad++; $display("FAIL bypass_off got=%b want=0", take_nb); end
        tick();
        flag_we = 0;
        #1;
        total++; if (take_nb !== 1'b1) begin bad++; $display("FAIL bypass_off_after got=%b want=1", take_nb); end
        idle();
    endtask

    task automatic test_cond_sweep();
        do_reset();
        for (int f = 0; f < 16; f++) begin
            flag_we = 1; set_alu(4'(f)); cond_valid = 0;
            tick();
            flag_we = 0; set_alu(4'(~f));
            for (int c = 0; c < 8; c++) begin
                cond = 3'(c); cond_valid = 1;
                #1;
                total++;
                if (take !== exp_take(3'(c), 4'(f)))
                    begin bad++; $display("FAIL sweep cond=%0d flags=%b got=%b want=%b", c, 4'(f), take, exp_take(3'(c), 4'(f))); end
                cond_valid = 0;
                #1;
                total++; if (take !== 1'b0) begin bad++; $display("FAIL sweep_novalid cond=%0d got=%b want=0", c, take); end
            end
        end
        flag_we = 1; set_alu(4'b0110);
        tick();
        flag_we = 0; cond_valid = 1; cond = 3'b011;
        #1;
        total++; if (take !== 1'b0) begin bad++; $display("FAIL lt_n1v1 got=%b want=0", take); end
        flag_we = 1; set_alu(4'b0010);
        tick();
        flag_we = 0; cond = 3'b101;
        #1;
        total++; if (take !== 1'b1) begin bad++; $display("FAIL le_n0v1 got=%b want=1", take); end
        idle();
    endtask

    task automatic test_push_pop();
        do_reset();
        flag_we = 1; set_alu(4'b0101);
        tick();
        flag_we = 0; flag_push = 1;
        tick();
        flag_push = 0;
        total++; if (depth !== 3'd1) begin bad++; $display("FAIL pp_depth1 got=%0d want=1", depth); end
        flag_we = 1; set_alu(4'b0010);
        tick();
        flag_we = 0;
        total++; if (flags !== 4'b0010) begin bad++; $display("FAIL pp_mid got=%b want=0010", flags); end
        flag_pop = 1; flag_we = 1; set_alu(4'b1111);
        tick();
        idle();
        total++; if (flags !== 4'b0101) begin bad++; $display("FAIL pp_restore got=%b want=0101", flags); end
        total++; if (depth !== 3'd0 || err !== 1'b0) begin bad++; $display("FAIL pp_depth_err got=%0d/%b want=0/0", depth, err); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            flag_push = 1; flag_we = 1; set_alu(4'(i + 1));
            tick();
            if (i == 3) begin
                total++; if (depth !== 3'd4 || full !== 1'b1 || err !== 1'b0)
                    begin bad++; $display("FAIL ovf_4th depth/full/err got=%0d/%b/%b want=4/1/0", depth, full, err); end
            end
        end
        idle();
        total++; if (depth !== 3'd4 || err !== 1'b1) begin bad++; $display("FAIL ovf_5th depth/err got=%0d/%b want=4/1", depth, err); end
        total++; if (flags !== 4'd5) begin bad++; $display("FAIL ovf_flag_we got=%0d want=5", flags); end
        for (int i = 0; i < 4; i++) begin
            flag_pop = 1;
            tick();
            total++; if (flags !== 4'(3 - i) || depth !== 3'(3 - i))
                begin bad++; $display("FAIL lifo pop%0d flags/depth got=%0d/%0d want=%0d/%0d", i, flags, depth, 3 - i, 3 - i); end
        end
        tick();
        flag_pop = 0;
        total++; if (flags !== 4'd0 || depth !== 3'd0 || err !== 1'b1 || empty !== 1'b1)
            begin bad++; $display("FAIL underflow flags/depth/err/empty got=%0d/%0d/%b/%b want=0/0/1/1", flags, depth, err, empty); end
        flag_pop = 1; flag_we = 1; set_alu(4'b1001);
        tick();
        flag_push = 1; flag_pop = 1; set_alu(4'b1010);
        tick();
        idle();
        total++; if (flags !== 4'b1010 || depth !== 3'd0 || err !== 1'b1)
            begin bad++; $display("FAIL empty_ops_we flags/depth/err got=%b/%0d/%b want=1010/0/1", flags, depth, err); end
    endtask

    task automatic test_swap_reset();
        realtime t0;
        do_reset();
        flag_we = 1; set_alu(4'd1); tick();
        flag_we = 0; flag_push = 1; tick();
        flag_push = 0; flag_we = 1; set_alu(4'd2); tick();
        flag_we = 0; flag_push = 1; tick();
        flag_push = 0; flag_we = 1; set_alu(4'd7); tick();
        flag_we = 1; set_alu(4'd12); flag_push = 1; flag_pop = 1;
        tick();
        idle();
        total++; if (flags !== 4'd2 || depth !== 3'd2 || err !== 1'b0)
            begin bad++; $display("FAIL swap flags/depth/err got=%0d/%0d/%b want=2/2/0", flags, depth, err); end
        flag_pop = 1; tick();
        flag_pop = 0;
        total++; if (flags !== 4'd7 || depth !== 3'd1) begin bad++; $display("FAIL swap_top flags/depth got=%0d/%0d want=7/1", flags, depth); end
        flag_push = 1; tick();
        flag_push = 0;
        #2;
        t0 = $realtime;
        rst_n = 0;
        #1;
        total++; if (depth !== 3'd0 || flags !== 4'd0 || empty !== 1'b1 || ($realtime - t0) >= 5.0)
            begin bad++; $display("FAIL async_rst depth/flags/empty got=%0d/%0d/%b want=0/0/1", depth, flags, empty); end
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 1;
        test_reset();
        test_flag_update();
        test_bypass();
        test_cond_sweep();
        test_push_pop();
        test_overflow();
        test_swap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
